// File: rtl/number_pkg.sv
// Shared constants, FSM state type and sizing helper for the number classifier.
package number_pkg;

  localparam logic [7:0] NO_CHAR = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDecide
  } state_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/number_stability_filter.sv
// Cross-frame filter: a candidate must repeat STABLE_FRAMES times before it is shown.
module number_stability_filter
  import number_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic       cand_valid_i,
  input  logic [7:0] cand_class_i,
  input  logic       clear_i,
  output logic [7:0] char_result_number_o,
  output logic       result_locked_o
);

  localparam int unsigned CntW = clog2(STABLE_FRAMES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_FRAMES);

  logic [7:0]      prev_q, prev_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      char_q, char_d;
  logic            locked_q, locked_d;

  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    char_d   = char_q;
    locked_d = locked_q;
    if (cand_valid_i) begin
      if (cand_class_i == prev_q) begin
        if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      end else begin
        prev_d = cand_class_i;
        cnt_d  = CntW'(1);
      end
      // A stable "no character" run unlocks but keeps the last shown digit.
      if ((cnt_d == CntMax) && (cand_class_i != NO_CHAR)) begin
        char_d   = cand_class_i;
        locked_d = 1'b1;
      end else begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= NO_CHAR;
      cnt_q    <= '0;
      char_q   <= NO_CHAR;
      locked_q <= 1'b0;
    end else if (clear_i) begin
      prev_q   <= NO_CHAR;
      cnt_q    <= '0;
      char_q   <= NO_CHAR;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      char_q   <= char_d;
      locked_q <= locked_d;
    end
  end

  assign char_result_number_o = char_q;
  assign result_locked_o      = locked_q;

endmodule

// File: rtl/number_classifier.sv
// Per-frame best/runner-up scan over template scores with threshold, margin and
// a cross-frame stability filter feeding the character display path.
module number_classifier
  import number_pkg::*;
#(
  parameter int unsigned NUM_CLASS     = 10,
  parameter int unsigned SCORE_W       = 12,
  parameter int unsigned THRESH        = 1024,
  parameter int unsigned MARGIN        = 64,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                         pixelclk,
  input  logic                         reset_n,
  input  logic                         frame_done,
  input  logic [NUM_CLASS*SCORE_W-1:0] score_bus,
  input  logic                         clear,
  output logic                         busy,
  output logic                         cand_valid,
  output logic [7:0]                   cand_class,
  output logic [SCORE_W-1:0]           cand_score,
  output logic [7:0]                   char_result_number,
  output logic                         result_locked,
  output logic                         overrun
);

  localparam int unsigned IdxW = clog2(NUM_CLASS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_CLASS - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [IdxW-1:0]     best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]  best_q, best_d;
  logic [SCORE_W-1:0]  second_q, second_d;
  logic                cand_valid_q, cand_valid_d;
  logic [7:0]          cand_class_q, cand_class_d;
  logic [SCORE_W-1:0]  cand_score_q, cand_score_d;
  logic                overrun_q, overrun_d;
  logic [SCORE_W-1:0]  snap_q [NUM_CLASS];
  logic                load_snap;
  logic [SCORE_W-1:0]  cur_score;
  logic [SCORE_W-1:0]  gap;
  logic [7:0]          decide_cand;
  logic                decide_fire;

  assign cur_score   = snap_q[idx_q];
  assign gap         = best_q - second_q;
  assign decide_cand = ((32'(best_q) > THRESH) && (32'(gap) >= MARGIN)) ? 8'(best_idx_q) : NO_CHAR;
  assign decide_fire = (state_q == StDecide);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_idx_d   = best_idx_q;
    best_d       = best_q;
    second_d     = second_q;
    cand_valid_d = 1'b0;
    cand_class_d = cand_class_q;
    cand_score_d = cand_score_q;
    overrun_d    = overrun_q;
    load_snap    = 1'b0;
    if (clear) begin
      state_d      = StIdle;
      cand_class_d = NO_CHAR;
      cand_score_d = '0;
      overrun_d    = 1'b0;
    end else begin
      if (frame_done && (state_q != StIdle)) overrun_d = 1'b1;
      case (state_q)
        StIdle: begin
          if (frame_done) begin
            load_snap  = 1'b1;
            best_d     = '0;
            second_d   = '0;
            best_idx_d = '0;
            idx_d      = '0;
            state_d    = StScan;
          end
        end
        StScan: begin
          // Strict compare keeps the lowest index on ties.
          if (cur_score > best_q) begin
            second_d   = best_q;
            best_d     = cur_score;
            best_idx_d = idx_q;
          end else if (cur_score > second_q) begin
            second_d = cur_score;
          end
          if (idx_q == IdxLast) state_d = StDecide;
          else                  idx_d   = idx_q + 1'b1;
        end
        StDecide: begin
          cand_valid_d = 1'b1;
          cand_class_d = decide_cand;
          cand_score_d = best_q;
          state_d      = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_q       <= '0;
      second_q     <= '0;
      cand_valid_q <= 1'b0;
      cand_class_q <= NO_CHAR;
      cand_score_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_idx_q   <= best_idx_d;
      best_q       <= best_d;
      second_q     <= second_d;
      cand_valid_q <= cand_valid_d;
      cand_class_q <= cand_class_d;
      cand_score_q <= cand_score_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CLASS; i++) snap_q[i] <= '0;
    end else if (load_snap) begin
      for (int i = 0; i < NUM_CLASS; i++) snap_q[i] <= score_bus[i*SCORE_W +: SCORE_W];
    end
  end

  number_stability_filter #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_filter (
    .pixelclk             (pixelclk),
    .reset_n              (reset_n),
    .cand_valid_i         (decide_fire),
    .cand_class_i         (decide_cand),
    .clear_i              (clear),
    .char_result_number_o (char_result_number),
    .result_locked_o      (result_locked)
  );

  assign busy       = (state_q != StIdle);
  assign cand_valid = cand_valid_q;
  assign cand_class = cand_class_q;
  assign cand_score = cand_score_q;
  assign overrun    = overrun_q;

endmodule
